fread_responder: RTL

- Serves the "fread" request/response stream consumed by the Forth core's boot loader: answers a `req_valid`/`req_ready` request, then emits exactly LEN bytes on `resp_data`/`resp_valid`.
- Bytes arrive from the ESP32 link side on a ready/valid byte port and are buffered in an internal FIFO.
- Sits between the SPI/ESP byte receiver and the j1 loader port. It is the responder end of the loader's initiator.

---
 rtl/fread_pkg.sv | 24 ++
 rtl/fread_byte_fifo.sv | 60 ++++++
 rtl/fread_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fread_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fread_pkg
// Purpose  : Shared constants and state encoding for the fread responder.
// Revision : 1.0 - initial release
// ============================================================================
package fread_pkg;

    localparam int c_CNT_W = 16;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACK    = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_ACK    = c_ST_ACK,
        ST_STREAM = c_ST_STREAM,
        ST_DONE   = c_ST_DONE
    } fread_state_t;

endpackage
`default_nettype wire

// File: rtl/fread_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fread_byte_fifo
// Purpose  : Synchronous byte FIFO, 2**DEPTH_LOG2 deep, registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module fread_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0]          r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [7:0]          r_rd_data;
    logic                w_do_wr;
    logic                w_do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;
    assign rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= 8'h00;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2 + 1)'(1);
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
                r_rd_ptr  <= r_rd_ptr + (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fread_responder.sv
`default_nettype none
// ============================================================================
// Module   : fread_responder
// Purpose  : Answers a loader request with LEN buffered bytes from the ESP link.
//            Define FREAD_CHECKSUM_EN to build the 16-bit transfer checksum.
// Revision : 1.0 - initial release
// ============================================================================
module fread_responder
    import fread_pkg::*;
#(
    parameter int LEN        = 2048,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP        = 0
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    localparam int                 c_GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LEN   = LEN[c_CNT_W-1:0];
    localparam logic [c_GAP_W-1:0] c_GAP   = GAP[c_GAP_W-1:0];

    if (LEN < 1 || LEN > 65535) begin : g_len_check
        $error("fread_responder: LEN must be within 1..65535");
    end

    if (DEPTH_LOG2 < 1) begin : g_depth_check
        $error("fread_responder: DEPTH_LOG2 must be at least 1");
    end

    fread_state_t       r_state;
    fread_state_t       w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_resp_valid;
    logic               r_busy;
    logic               r_done;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [7:0]         w_rd_data;

    fread_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .wr_en   (src_valid),
        .wr_data (src_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign src_ready  = ~w_full;
    assign req_ready  = (r_state == ST_ACK);
    assign resp_data  = w_rd_data;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (!w_empty && r_gap == '0) begin
                    w_pop = 1'b1;
                    if (r_count == c_CNT_W'(1)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The gap counter is cleared in ACK so a new transfer never inherits the
    // spacing left over from the previous one's final byte.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_count      <= '0;
            r_gap        <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_resp_valid <= w_pop;
            r_done       <= (r_state == ST_DONE);
            case (r_state)
                ST_ACK: begin
                    r_count <= c_LEN;
                    r_gap   <= '0;
                    r_busy  <= 1'b1;
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_count <= r_count - c_CNT_W'(1);
                        r_gap   <= c_GAP;
                    end else if (r_gap != '0) begin
                        r_gap <= r_gap - c_GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FREAD_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_checksum <= 16'h0000;
        end else if (r_state == ST_ACK) begin
            r_checksum <= 16'h0000;
        end else if (r_resp_valid) begin
            r_checksum <= r_checksum + {8'h00, w_rd_data};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire
